// File: rtl/instruction_fetch_sequencer.sv
// instruction_fetch_sequencer: two-byte instruction fetch, one-cycle decode and N-cycle execute sequencer.
// Defining IFS_STEP_EN adds a HOLD state after each instruction that waits for a Step pulse.
module instruction_fetch_sequencer #(
    parameter int T_WIDTH = 3
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Go,
    input  logic               MemReady,
    input  logic [T_WIDTH-1:0] ExecCycles,
    input  logic               ExecAbort,
    input  logic               Step,
    output logic               IR_Write,
    output logic               IR_LH,
    output logic               PC_Inc,
    output logic               MemRead,
    output logic [T_WIDTH-1:0] T,
    output logic [2:0]         State,
    output logic               InstrDone
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_L = 3'd1,
        FETCH_H = 3'd2,
        DECODE  = 3'd3,
        EXEC    = 3'd4,
        HOLD    = 3'd5
    } state_e;

    localparam logic [T_WIDTH-1:0] ONE = T_WIDTH'(1);

    state_e             state_q, state_d, after_exec;
    logic [T_WIDTH-1:0] t_q, t_d, n_q, n_d;
    logic               fetch, last;

`ifdef IFS_STEP_EN
    assign after_exec = HOLD;
`else
    logic unused_step;
    assign unused_step = Step;
    assign after_exec  = Go ? FETCH_L : IDLE;
`endif

    always_comb begin
        fetch     = state_q == FETCH_L || state_q == FETCH_H;
        last      = state_q == EXEC && (ExecAbort || t_q == n_q - ONE);
        MemRead   = fetch;
        IR_Write  = fetch && MemReady;
        PC_Inc    = fetch && MemReady;
        IR_LH     = state_q == FETCH_H;
        InstrDone = last;
        T         = t_q;
        State     = state_q;
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        n_d     = n_q;
        case (state_q)
            IDLE:    state_d = Go ? FETCH_L : IDLE;
            FETCH_L: state_d = MemReady ? FETCH_H : FETCH_L;
            FETCH_H: state_d = MemReady ? DECODE : FETCH_H;
            DECODE: begin
                n_d     = ExecCycles == '0 ? ONE : ExecCycles;
                t_d     = '0;
                state_d = EXEC;
            end
            EXEC: begin
                t_d     = last ? '0 : t_q + ONE;
                state_d = last ? after_exec : EXEC;
            end
`ifdef IFS_STEP_EN
            HOLD:    state_d = Step ? (Go ? FETCH_L : IDLE) : HOLD;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            t_q     <= '0;
            n_q     <= ONE;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            n_q     <= n_d;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// tb_instruction_fetch_sequencer: directed bench for instruction_fetch_sequencer, default build.
module tb_instruction_fetch_sequencer;
    logic       Clock = 1'b0, Reset = 1'b0, Go = 1'b0, MemReady = 1'b0, ExecAbort = 1'b0, Step = 1'b0;
    logic [2:0] ExecCycles = 3'd0;
    logic       IR_Write, IR_LH, PC_Inc, MemRead, InstrDone;
    logic [2:0] T, State;
    int         n_chk = 0, n_fail = 0;

    instruction_fetch_sequencer #(.T_WIDTH(3)) dut (
        .Clock(Clock), .Reset(Reset), .Go(Go), .MemReady(MemReady), .ExecCycles(ExecCycles),
        .ExecAbort(ExecAbort), .Step(Step), .IR_Write(IR_Write), .IR_LH(IR_LH), .PC_Inc(PC_Inc),
        .MemRead(MemRead), .T(T), .State(State), .InstrDone(InstrDone)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // checks every output one tick after inputs settle, then advances one clock
    task automatic cyc(input string tag, input int st, input int irw, input int lh, input int pci,
                       input int mr, input int t, input int done);
        #1;
        chk({tag, ".state"}, 32'(State), 32'(st));
        chk({tag, ".ir_write"}, 32'(IR_Write), 32'(irw));
        chk({tag, ".ir_lh"}, 32'(IR_LH), 32'(lh));
        chk({tag, ".pc_inc"}, 32'(PC_Inc), 32'(pci));
        chk({tag, ".mem_read"}, 32'(MemRead), 32'(mr));
        chk({tag, ".t"}, 32'(T), 32'(t));
        chk({tag, ".done"}, 32'(InstrDone), 32'(done));
        @(posedge Clock);
        #1;
    endtask

    initial begin
        #3;
        chk("rst.state", 32'(State), 0);
        chk("rst.t", 32'(T), 0);
        chk("rst.strobes", {28'd0, IR_Write, PC_Inc, MemRead, InstrDone}, 0);
        #10;
        Reset = 1'b1;
        Go = 1'b1;
        MemReady = 1'b1;
        ExecCycles = 3'd3;
        #1;
        chk("post_rst.idle", 32'(State), 0);
        @(posedge Clock);
        #1;
        // basic three-cycle instruction
        cyc("b_fl", 1, 1, 0, 1, 1, 0, 0);
        cyc("b_fh", 2, 1, 1, 1, 1, 0, 0);
        cyc("b_dec", 3, 0, 0, 0, 0, 0, 0);
        cyc("b_ex0", 4, 0, 0, 0, 0, 0, 0);
        cyc("b_ex1", 4, 0, 0, 0, 0, 1, 0);
        MemReady = 1'b0;
        cyc("b_ex2", 4, 0, 0, 0, 0, 2, 1);
        // FETCH_L stall for four cycles
        for (int i = 0; i < 4; i++) cyc("stall", 1, 0, 0, 0, 1, 0, 0);
        MemReady = 1'b1;
        cyc("s_fl", 1, 1, 0, 1, 1, 0, 0);
        ExecCycles = 3'd7;
        cyc("s_fh", 2, 1, 1, 1, 1, 0, 0);
        cyc("s_dec", 3, 0, 0, 0, 0, 0, 0);
        cyc("a_ex0", 4, 0, 0, 0, 0, 0, 0);
        ExecAbort = 1'b1;
        cyc("a_ex1", 4, 0, 0, 0, 0, 1, 1);
        ExecAbort = 1'b0;
        ExecCycles = 3'd0;
        cyc("z_fl", 1, 1, 0, 1, 1, 0, 0);
        Go = 1'b0;
        cyc("z_fh", 2, 1, 1, 1, 1, 0, 0);
        cyc("z_dec", 3, 0, 0, 0, 0, 0, 0);
        cyc("z_ex0", 4, 0, 0, 0, 0, 0, 1);
        ExecAbort = 1'b1;
        cyc("idle_abort", 0, 0, 0, 0, 0, 0, 0);
        ExecAbort = 1'b0;
        cyc("idle_stay", 0, 0, 0, 0, 0, 0, 0);
        // asynchronous reset in the middle of FETCH_H
        Go = 1'b1;
        cyc("r_idle", 0, 0, 0, 0, 0, 0, 0);
        cyc("r_fl", 1, 1, 0, 1, 1, 0, 0);
        #2;
        Reset = 1'b0;
        #1;
        chk("arst.state", 32'(State), 0);
        chk("arst.strobes", {28'd0, IR_Write, PC_Inc, MemRead, IR_LH}, 0);
        #1;
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        // restart, Step toggling has no effect without single-step support
        ExecCycles = 3'd2;
        cyc("rs_fl", 1, 1, 0, 1, 1, 0, 0);
        Step = 1'b1;
        cyc("rs_fh", 2, 1, 1, 1, 1, 0, 0);
        Step = 1'b0;
        cyc("rs_dec", 3, 0, 0, 0, 0, 0, 0);
        Step = 1'b1;
        cyc("rs_ex0", 4, 0, 0, 0, 0, 0, 0);
        Step = 1'b0;
        cyc("rs_ex1", 4, 0, 0, 0, 0, 1, 1);
        cyc("rs_next", 1, 1, 0, 1, 1, 0, 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
